// File: rtl/irq_encoder_16_to_4_pkg.sv
// Shared constants, state encoding and helpers for the 16-to-4 request encoder.
package irq_enc_pkg;

  localparam int N_REQ  = 16;
  localparam int CODE_W = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // One-hot of a code; the inverse of the encoder, used to clear a served line.
  function automatic logic [N_REQ-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
    return N_REQ'(1) << code;
  endfunction

endpackage

// File: rtl/irq_encoder_16_to_4_if.sv
// Code/valid/ack handshake between the encoder (master) and the control unit (slave).
interface irq_encoder_16_to_4_if;
  import irq_enc_pkg::*;

  logic [CODE_W-1:0] code_out;
  logic              valid_out;
  logic              ack_in;

  modport master (output code_out, output valid_out, input ack_in);
  modport slave  (input code_out, input valid_out, output ack_in);

endinterface

// File: rtl/prio_enc_16_to_4.sv
// Combinational find-first-set: lowest set bit wins; all-zero gives index 0, found 0.
module prio_enc_16_to_4
  import irq_enc_pkg::*;
(
  input  logic [N_REQ-1:0]  vec,
  output logic [CODE_W-1:0] idx,
  output logic              found
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    idx   = '0;
    found = |vec;
    // Scanning downward lets the lowest set bit overwrite any higher one.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = CODE_W'(i);
    end
  end

endmodule

// File: rtl/irq_encoder_16_to_4.sv
// Sticky 16-line request latch presenting one pending, unmasked index at a time over valid/ack.
module irq_encoder_16_to_4
  import irq_enc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_in,
  input  logic [N_REQ-1:0]      mask_in,
  output logic [N_REQ-1:0]      pending_out,
  output logic                  any_pending_out,
  irq_encoder_16_to_4_if.master bus
);

  state_t            state;
  logic [N_REQ-1:0]  pending;
  logic [N_REQ-1:0]  clr;
  logic [CODE_W-1:0] sel_idx;
  logic              sel_found;

  prio_enc_16_to_4 u_prio (
    .vec   (pending & ~mask_in),
    .idx   (sel_idx),
    .found (sel_found)
  );

  // Only a handshake that actually completes clears the presented line.
  assign clr = (bus.valid_out && bus.ack_in) ? code_to_onehot(bus.code_out) : '0;

  assign pending_out     = pending;
  assign any_pending_out = sel_found;

  // NOTE: reset is synchronous (sampled on the clock edge) and all state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      pending       <= '0;
      bus.code_out  <= '0;
      bus.valid_out <= 1'b0;
    end else begin
      // A fresh request in the ack cycle re-sets the bit being cleared.
      pending <= (pending & ~clr) | req_in;
      case (state)
        IDLE: begin
          if (sel_found) begin
            bus.code_out  <= sel_idx;
            bus.valid_out <= 1'b1;
            state         <= PRESENT;
          end
        end
        PRESENT: begin
          // code_out is frozen here; it keeps its value after ack as well.
          if (bus.ack_in) begin
            bus.valid_out <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_encoder_16_to_4.sv
// Self-checking bench: expected codes queued at stimulus time, popped on each new presentation.
module tb_irq_encoder_16_to_4;
  import irq_enc_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_REQ-1:0] req_in;
  logic [N_REQ-1:0] mask_in;
  logic [N_REQ-1:0] pending_out;
  logic             any_pending_out;

  irq_encoder_16_to_4_if bus ();

  irq_encoder_16_to_4 dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_in          (req_in),
    .mask_in         (mask_in),
    .pending_out     (pending_out),
    .any_pending_out (any_pending_out),
    .bus             (bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int sb[$];
  logic prev_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every rising valid_out is a new presentation, compared against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (rst_n && bus.valid_out && !prev_valid) begin
      if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
      else check("sb_code", 32'(bus.code_out), 32'(sb.pop_front()));
    end
    prev_valid = bus.valid_out;
  end

  initial begin
    rst_n      = 1'b0;
    req_in     = '0;
    mask_in    = '0;
    bus.ack_in = 1'b0;
    tick(2);
    rst_n = 1'b1;

    // Reset then idle.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_valid", 32'(bus.valid_out), 32'd0);
      check("idle_code", 32'(bus.code_out), 32'd0);
      check("idle_pending", 32'(pending_out), 32'h0);
    end

    // Single request on line 8.
    req_in = 16'h0100; sb.push_back(8);
    tick(); req_in = '0;
    check("single_pending", 32'(pending_out), 32'h0100);
    check("single_valid_early", 32'(bus.valid_out), 32'd0);
    tick();
    check("single_valid", 32'(bus.valid_out), 32'd1);
    check("single_code", 32'(bus.code_out), 32'd8);
    check("single_any", 32'(any_pending_out), 32'd1);
    bus.ack_in = 1'b1;
    tick(); bus.ack_in = 1'b0;
    check("single_clr_pending", 32'(pending_out), 32'h0);
    check("single_clr_valid", 32'(bus.valid_out), 32'd0);
    check("single_clr_any", 32'(any_pending_out), 32'd0);
    check("code_held_after_ack", 32'(bus.code_out), 32'd8);

    // Four lines, ack held high: valid on alternate cycles, codes 0,5,10,15.
    req_in = 16'h8421;
    sb.push_back(0); sb.push_back(5); sb.push_back(10); sb.push_back(15);
    tick(); req_in = '0; bus.ack_in = 1'b1;
    check("multi_pending", 32'(pending_out), 32'h8421);
    for (int k = 1; k <= 9; k++) begin
      check("multi_valid", 32'(bus.valid_out), 32'((k % 2) == 0));
      tick();
    end
    bus.ack_in = 1'b0;
    check("multi_drained", 32'(pending_out), 32'h0);

    // Masked line 0 defers to line 1, then is served after unmasking.
    mask_in = 16'h0001; req_in = 16'h0003; sb.push_back(1);
    tick(); req_in = '0;
    check("mask_pending", 32'(pending_out), 32'h0003);
    tick();
    check("mask_code", 32'(bus.code_out), 32'd1);
    bus.ack_in = 1'b1; mask_in = '0; sb.push_back(0);
    tick(); bus.ack_in = 1'b0;
    check("mask_after_ack", 32'(pending_out), 32'h0001);
    tick();
    check("unmask_code", 32'(bus.code_out), 32'd0);
    // Masking the presented line mid-PRESENT does not disturb it.
    mask_in = 16'h0001;
    tick();
    check("masked_present_valid", 32'(bus.valid_out), 32'd1);
    check("masked_present_code", 32'(bus.code_out), 32'd0);
    bus.ack_in = 1'b1;
    tick(); bus.ack_in = 1'b0; mask_in = '0;
    check("masked_present_done", 32'(pending_out), 32'h0);

    // Ack while valid is low is ignored.
    req_in = 16'h0010; sb.push_back(4);
    tick(); req_in = '0; bus.ack_in = 1'b1;
    tick();
    check("early_ack_pending", 32'(pending_out), 32'h0010);
    check("early_ack_valid", 32'(bus.valid_out), 32'd1);
    tick(); bus.ack_in = 1'b0;
    check("early_ack_done", 32'(pending_out), 32'h0);

    // Ack and re-request on line 3 in the same cycle.
    req_in = 16'h0008; sb.push_back(3);
    tick(); req_in = '0;
    tick();
    check("rereq_code", 32'(bus.code_out), 32'd3);
    bus.ack_in = 1'b1; req_in = 16'h0008; sb.push_back(3);
    tick(); bus.ack_in = 1'b0; req_in = '0;
    check("rereq_pending", 32'(pending_out), 32'h0008);
    check("rereq_bubble", 32'(bus.valid_out), 32'd0);
    tick();
    check("rereq_valid", 32'(bus.valid_out), 32'd1);
    bus.ack_in = 1'b1;
    tick(); bus.ack_in = 1'b0;
    check("rereq_done", 32'(pending_out), 32'h0);

    // Reset while presenting code 7 with pending 0x0081.
    mask_in = 16'h0001; req_in = 16'h0081; sb.push_back(7);
    tick(); req_in = '0;
    tick();
    check("rst_pre_code", 32'(bus.code_out), 32'd7);
    check("rst_pre_pending", 32'(pending_out), 32'h0081);
    rst_n = 1'b0;
    tick();
    check("rst_valid", 32'(bus.valid_out), 32'd0);
    check("rst_pending", 32'(pending_out), 32'h0);
    check("rst_code", 32'(bus.code_out), 32'd0);
    rst_n = 1'b1; mask_in = '0; bus.ack_in = 1'b1;
    tick();
    check("post_rst_ack_pending", 32'(pending_out), 32'h0);
    check("post_rst_ack_valid", 32'(bus.valid_out), 32'd0);
    tick(); bus.ack_in = 1'b0;
    check("post_rst_idle", 32'(bus.valid_out), 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/irq_encoder_16_to_4.md
Name: irq_encoder_16_to_4

Overview:
- Sequential 16-to-4 request encoder, the inverse of the core's 4-to-16 one-hot decoder.
- Latches 16 request lines into a sticky pending register and presents one pending index at a time as a 4-bit code with a valid/ack handshake.
- Clears each served bit on acknowledge.
- Sits between peripheral interrupt/request lines and the control unit; the control unit's 4-to-16 decoder turns the code back into a one-hot select.

Parameters:
- N_REQ, 16, number of request lines; fixed at 16 for this revision.
- CODE_W, 4, code width; must equal log2(N_REQ).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- req_in  input  16  request lines; a bit sampled high on any clk edge sets the matching pending bit.
- mask_in  input  16  1 = line blocked from selection; its pending bit is still kept.
- code_out  output  4  index of the line being presented.
- valid_out  output  1  code_out holds a served request.
- ack_in  input  1  consumer accepts code_out.
- pending_out  output  16  current pending register.
- any_pending_out  output  1  OR of (pending & ~mask_in), combinational from registered pending.

Behaviour:
- Reset (rst_n low at a clk edge):
  - pending=0, code_out=0, valid_out=0, state=IDLE.
  - req_in is ignored that cycle.
- Pending update, every edge:
  - pending_next = (pending & ~clr) | req_in.
  - clr is the one-hot of code_out when valid_out & ack_in, else 0.
  - A request on the same line in the ack cycle wins, so that bit stays set.
- Selection is fixed priority: lowest index wins (bit 0 → code 0, bit 15 → code 15). Selection uses pending & ~mask_in from registered pending only.
- States:
  - IDLE: if (pending & ~mask_in) != 0, then code_out <= selected index, valid_out <= 1, go PRESENT. Else stay in IDLE.
  - PRESENT:
    - code_out is held stable while valid_out=1. Mask or req changes do not alter it.
    - On ack_in=1: valid_out <= 0, clear the served bit, go IDLE.
- Latency:
  - Request sampled at edge N → pending visible after N → valid_out high after edge N+1.
  - Back-to-back service costs one IDLE bubble, so throughput is at most one code per 2 cycles.
- ack_in while valid_out=0 is ignored, with no effect on pending.
- The presented line becoming masked during PRESENT still completes normally.
- All 16 lines pending: served 0,1,…,15 in order if none re-assert. A re-asserting low line can starve higher lines; this is by design.
- Reset mid-PRESENT drops valid_out and clears all pending on that edge. The lost request is not recovered.
- code_out keeps its last value after ack; consumers qualify it with valid_out.

Decomposition:
- Shared package `irq_enc_pkg`:
  - N_REQ and CODE_W constants.
  - State enum: IDLE=1'b0, PRESENT=1'b1.
- One sub-module `prio_enc_16_to_4`: purely combinational find-first-set.
  - Inputs: 16-bit vector.
  - Outputs: 4-bit index and a found flag.
  - All-zero input gives index 0, found=0.

Test Plan:
- Reset then idle, req_in=0 → valid_out=0, code_out=0, pending_out=0x0000 for 10 cycles.
- Single request req_in=0x0100 pulsed 1 cycle → pending_out=0x0100; valid_out=1 with code_out=8 two edges after the pulse; ack → pending_out=0x0000, valid_out=0.
- Multi request req_in=0x8421 pulsed, ack held high → codes 0,5,10,15 in order, each valid for 1 cycle, separated by 1 idle cycle.
- Mask: pending 0x0003, mask_in=0x0001 → code 1 first; unmask → code 0 next.
- Simultaneous ack and re-request on line 3 with code_out=3 → pending bit 3 stays 1; code 3 is presented again after the bubble.
- Reset asserted while valid_out=1 (code 7, pending 0x0081) → the next edge gives valid_out=0, pending_out=0x0000; a later ack_in is ignored.
